// File: rtl/spk_pkg.sv
// Shared types for the spike packet builder: packet header, word indices,
// serializer states and the 128-bit event entry carried through the FIFO.
package spk_pkg;

    localparam logic [7:0] PKT_HDR = 8'hA5;

    localparam logic [1:0] WIDX_HDR      = 2'd0;
    localparam logic [1:0] WIDX_FRAME    = 2'd1;
    localparam logic [1:0] WIDX_VALUE    = 2'd2;
    localparam logic [1:0] WIDX_UNIGROUP = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        W1,
        W2,
        W3
    } spk_state_e;

    typedef struct packed {
        logic [31:0] hdr;
        logic [31:0] frame;
        logic [31:0] value;
        logic [31:0] unigroup;
    } spk_entry_t;

    function automatic logic [31:0] spk_hdr_word(input logic [7:0] stream_no,
                                                 input logic [7:0] ch);
        return {PKT_HDR, stream_no, 8'h00, ch};
    endfunction

    function automatic logic [31:0] spk_word(input spk_entry_t e,
                                             input logic [1:0] idx);
        logic [31:0] w;
        w = e.hdr;
        case (idx)
            WIDX_HDR:      w = e.hdr;
            WIDX_FRAME:    w = e.frame;
            WIDX_VALUE:    w = e.value;
            WIDX_UNIGROUP: w = e.unigroup;
            default:       w = e.hdr;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/spk_evt_fifo.sv
// Synchronous show-ahead event FIFO; a pop in the same cycle as a push
// frees the slot first, so a write into a full FIFO still lands.
module spk_evt_fifo
    import spk_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  spk_entry_t wr_data_i,
    input  logic       rd_en_i,
    output spk_entry_t rd_data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       wr_ok_o
);

    localparam int AW = $clog2(DEPTH);

    spk_entry_t    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          rd_fire;
    logic          wr_fire;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_fire   = rd_en_i && !empty_o;
    assign wr_fire   = wr_en_i && (!full_o || rd_fire);
    assign wr_ok_o   = wr_fire;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/spk_pkt_builder.sv
// Timestamps flagged peaks with the frame counter, queues them and emits
// 4-word packets on a valid/ready stream. SPK_REFRACTORY_EN adds per-channel
// refractory suppression.
module spk_pkt_builder
    import spk_pkg::*;
#(
    parameter int NUM_CH     = 32,
    parameter int FIFO_DEPTH = 16
`ifdef SPK_REFRACTORY_EN
    ,
    parameter int REFRAC_FRAMES = 10
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        eof_in,
    input  logic [7:0]  ch_in,
    input  logic [31:0] ch_unigroup_in,
    input  logic [31:0] v_in,
    input  logic        is_peak_in,
    output logic [31:0] pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_last,
    output logic [31:0] frame_no,
    output logic [15:0] drop_cnt
);

    if (NUM_CH < 2 || NUM_CH > 256) begin : g_bad_num_ch
        $error("spk_pkt_builder: NUM_CH must be in 2..256");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spk_pkt_builder: FIFO_DEPTH must be a power of two >= 4");
    end

    logic [31:0] frame_q, frame_d;
    logic [15:0] drop_q, drop_d;

    logic        s1_valid_q;
    logic [7:0]  s1_ch_q;
    logic [31:0] s1_ug_q;
    logic [31:0] s1_v_q;
    logic [31:0] s1_frame_q;

    logic        s2_valid_q, s2_valid_d;
    spk_entry_t  s2_entry_q, s2_entry_d;
    logic        suppress;

    spk_entry_t  fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_wr_ok;
    logic        pop;
    logic        hs;

    spk_state_e  state_q;
    spk_entry_t  entry_q;
    logic [31:0] pkt_data_q;
    logic        pkt_valid_q;
    logic        pkt_last_q;

    // Frame counter: an event in the eof cycle is stamped with the old value.
    always_comb begin
        frame_d = frame_q;
        if (valid_in && eof_in) frame_d = frame_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q    <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            s1_valid_q <= valid_in && is_peak_in;
        end
        if (valid_in && is_peak_in) begin
            s1_ch_q    <= ch_in;
            s1_ug_q    <= ch_unigroup_in;
            s1_v_q     <= v_in;
            s1_frame_q <= frame_q;
        end
    end

`ifdef SPK_REFRACTORY_EN
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] armed_q;
    logic [31:0]       last_q [NUM_CH];
    logic [CH_W-1:0]   s1_idx;

    assign s1_idx   = s1_ch_q[CH_W-1:0];
    // Modulo-2^32 distance keeps the window correct across counter wrap.
    assign suppress = armed_q[s1_idx] &&
                      ((s1_frame_q - last_q[s1_idx]) < 32'(REFRAC_FRAMES));

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= '0;
        end else if (s1_valid_q && !suppress) begin
            armed_q[s1_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && s1_valid_q && !suppress) last_q[s1_idx] <= s1_frame_q;
    end
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        s2_valid_d = s1_valid_q && !suppress;
        s2_entry_d = '{hdr:      spk_hdr_word(s1_ug_q[7:0], s1_ch_q),
                       frame:    s1_frame_q,
                       value:    s1_v_q,
                       unigroup: s1_ug_q};
    end

    always_ff @(posedge clk) begin
        if (rst) s2_valid_q <= 1'b0;
        else     s2_valid_q <= s2_valid_d;
        s2_entry_q <= s2_entry_d;
    end

    always_comb begin
        drop_d = drop_q;
        if (s2_valid_q && !fifo_wr_ok && drop_q != '1) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    spk_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (s2_valid_q),
        .wr_data_i (s2_entry_q),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .wr_ok_o   (fifo_wr_ok)
    );

    assign hs  = pkt_valid_q && pkt_ready;
    assign pop = !fifo_empty && ((state_q == IDLE) || (state_q == W3 && hs));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        entry_q     <= fifo_rd;
                        pkt_data_q  <= spk_word(fifo_rd, WIDX_HDR);
                        pkt_valid_q <= 1'b1;
                        state_q     <= W0;
                    end
                end
                W0: begin
                    if (hs) begin
                        pkt_data_q <= spk_word(entry_q, WIDX_FRAME);
                        state_q    <= W1;
                    end
                end
                W1: begin
                    if (hs) begin
                        pkt_data_q <= spk_word(entry_q, WIDX_VALUE);
                        state_q    <= W2;
                    end
                end
                W2: begin
                    if (hs) begin
                        pkt_data_q <= spk_word(entry_q, WIDX_UNIGROUP);
                        pkt_last_q <= 1'b1;
                        state_q    <= W3;
                    end
                end
                W3: begin
                    if (hs) begin
                        pkt_last_q <= 1'b0;
                        if (pop) begin
                            entry_q    <= fifo_rd;
                            pkt_data_q <= spk_word(fifo_rd, WIDX_HDR);
                            state_q    <= W0;
                        end else begin
                            pkt_data_q  <= '0;
                            pkt_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    pkt_valid_q <= 1'b0;
                    pkt_last_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign pkt_data  = pkt_data_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_last  = pkt_last_q;
    assign frame_no  = frame_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_spk_pkt_builder.sv
// Self-checking bench for spk_pkt_builder: directed scenarios plus random
// traffic checked against a packet-level reference model.
module tb_spk_pkt_builder;

    localparam int NUM_CH = 32;
    localparam int DEPTH  = 16;
    localparam int REFRAC = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        eof_in;
    logic [7:0]  ch_in;
    logic [31:0] ch_unigroup_in;
    logic [31:0] v_in;
    logic        is_peak_in;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_last;
    logic [31:0] frame_no;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    spk_pkt_builder #(
        .NUM_CH        (NUM_CH),
        .FIFO_DEPTH    (DEPTH)
`ifdef SPK_REFRACTORY_EN
        ,
        .REFRAC_FRAMES (REFRAC)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .eof_in         (eof_in),
        .ch_in          (ch_in),
        .ch_unigroup_in (ch_unigroup_in),
        .v_in           (v_in),
        .is_peak_in     (is_peak_in),
        .pkt_data       (pkt_data),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_last       (pkt_last),
        .frame_no       (frame_no),
        .drop_cnt       (drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: expected word stream, captured words, counters.
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          widx     = 0;
    logic [31:0] frame_m  = '0;
    int          drop_m   = 0;
    bit          cap_mode = 1'b0;
    int          cap_used = 0;
    bit          armed_m [NUM_CH];
    logic [31:0] last_m  [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_evt(input logic [7:0] ch, input logic [31:0] ug, input logic [31:0] val);
`ifdef SPK_REFRACTORY_EN
        int unsigned i;
        i = ch % NUM_CH;
        if (armed_m[i] && (frame_m - last_m[i]) < REFRAC) return;
        armed_m[i] = 1'b1;
        last_m[i]  = frame_m;
`endif
        if (cap_mode) begin
            if (cap_used >= DEPTH) begin
                drop_m++;
                return;
            end
            cap_used++;
        end
        exp_q.push_back({8'hA5, ug[7:0], 8'h00, ch});
        exp_q.push_back(frame_m);
        exp_q.push_back(val);
        exp_q.push_back(ug);
    endtask

    task automatic model_reset();
        exp_q.delete();
        widx    = 0;
        frame_m = '0;
        drop_m  = 0;
        for (int i = 0; i < NUM_CH; i++) armed_m[i] = 1'b0;
    endtask

    // Output monitor: every valid word must be the model's next word.
    always @(negedge clk) begin
        if (rst === 1'b0 && pkt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {31'b0, pkt_valid}, 32'd0);
            end else begin
                chk("pkt_data", pkt_data, exp_q[0]);
                chk("pkt_last", {31'b0, pkt_last}, {31'b0, (widx == 3)});
                if (pkt_ready === 1'b1) begin
                    got_q.push_back(pkt_data);
                    void'(exp_q.pop_front());
                    widx = (widx + 1) % 4;
                end
            end
        end
    end

    task automatic sample(input bit v, input bit eof, input bit pk, input logic [7:0] ch,
                          input logic [31:0] ug, input logic [31:0] val);
        logic [31:0] vv;
        vv             = {val[31:1], pk};
        valid_in       = v;
        eof_in         = eof;
        is_peak_in     = v & pk;
        ch_in          = ch;
        ch_unigroup_in = ug;
        v_in           = vv;
        @(posedge clk);
        if (v && pk) model_evt(ch, ug, vv);
        if (v && eof) frame_m++;
        #1;
        valid_in   = 1'b0;
        eof_in     = 1'b0;
        is_peak_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int peak_ch, input logic [31:0] ug, input logic [31:0] val);
        for (int c = 0; c < NUM_CH; c++)
            sample(1'b1, c == NUM_CH - 1, c == peak_ch, 8'(c), ug, val);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", exp_q.size(), 32'd0);
        idle(3);
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; valid_in = 0; eof_in = 0; is_peak_in = 0;
        ch_in = '0; ch_unigroup_in = '0; v_in = '0; pkt_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pkt_valid", {31'b0, pkt_valid}, 32'd0);
        chk("rst_pkt_last",  {31'b0, pkt_last},  32'd0);
        chk("rst_pkt_data",  pkt_data, 32'd0);
        chk("rst_frame_no",  frame_no, 32'd0);
        chk("rst_drop_cnt",  {16'b0, drop_cnt}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Peak on ch 5 of frame 2.
        got_q.delete();
        run_frame(-1, 32'h0, 32'h0);
        run_frame(-1, 32'h0, 32'h0);
        run_frame(5, 32'h0706_0401, 32'hFFFF_FE0B);
        drain(200);
        chk("t1_words", got_q.size(), 32'd4);
        chk("t1_w0", got_q[0], 32'hA501_0005);
        chk("t1_w1", got_q[1], 32'h0000_0002);
        chk("t1_w2", got_q[2], 32'hFFFF_FE0B);
        chk("t1_w3", got_q[3], 32'h0706_0401);
        chk("t1_frame_no", frame_no, 32'd3);

        // Peak on the eof sample of frame 7.
        got_q.delete();
        for (int f = 3; f < 7; f++) run_frame(-1, 32'h0, 32'h0);
        run_frame(NUM_CH - 1, 32'h1234_5602, 32'h0000_0101);
        drain(200);
        chk("t2_words", got_q.size(), 32'd4);
        chk("t2_w1_frame", got_q[1], 32'd7);
        chk("t2_frame_no", frame_no, 32'd8);

        // Latency from idle: valid rises after the third edge past the sample.
        sample(1'b1, 1'b0, 1'b1, 8'd0, 32'hAABB_CC03, 32'h0000_0011);
        @(negedge clk); chk("lat_n0", {31'b0, pkt_valid}, 32'd0);
        @(negedge clk); chk("lat_n1", {31'b0, pkt_valid}, 32'd0);
        @(negedge clk); chk("lat_n2", {31'b0, pkt_valid}, 32'd0);
        @(negedge clk); chk("lat_n3", {31'b0, pkt_valid}, 32'd1);
        #1;
        drain(50);

        // Stall: one packet held in W0, then 20 peaks against a 16-deep FIFO.
        pkt_ready = 1'b0;
        got_q.delete();
        sample(1'b1, 1'b0, 1'b1, 8'd9, 32'h0000_0009, 32'h0000_0901);
        idle(6);
        chk("t3_held_valid", {31'b0, pkt_valid}, 32'd1);
        cap_mode = 1'b1;
        cap_used = 0;
        for (int i = 0; i < 20; i++)
            sample(1'b1, 1'b0, 1'b1, 8'(10 + i), 32'h5500_0000 | i, 32'h100 * i);
        idle(4);
        cap_mode = 1'b0;
        chk("t3_drop_cnt", {16'b0, drop_cnt}, 32'd4);
        chk("t3_drop_model", {16'b0, drop_cnt}, drop_m);
        pkt_ready = 1'b1;
        drain(400);
        chk("t3_words", got_q.size(), 32'd68);
        chk("t3_idle_after", {31'b0, pkt_valid}, 32'd0);

        // Ready toggling every cycle across two packets.
        got_q.delete();
        sample(1'b1, 1'b0, 1'b1, 8'd1, 32'hC0DE_0011, 32'hDEAD_0001);
        sample(1'b1, 1'b0, 1'b1, 8'd2, 32'hC0DE_0022, 32'hBEEF_0003);
        for (int i = 0; i < 40; i++) begin
            pkt_ready = ~pkt_ready;
            idle(1);
        end
        pkt_ready = 1'b1;
        drain(100);
        chk("t4_words", got_q.size(), 32'd8);

        // Reset in W1 with two packets still queued.
        pkt_ready = 1'b0;
        got_q.delete();
        sample(1'b1, 1'b0, 1'b1, 8'd6, 32'h0000_0A06, 32'h0000_0601);
        sample(1'b1, 1'b0, 1'b1, 8'd7, 32'h0000_0A07, 32'h0000_0701);
        sample(1'b1, 1'b0, 1'b1, 8'd8, 32'h0000_0A08, 32'h0000_0801);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (pkt_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t5_w0_up", {31'b0, pkt_valid}, 32'd1);
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t5_valid_after_rst", {31'b0, pkt_valid}, 32'd0);
        chk("t5_last_after_rst",  {31'b0, pkt_last},  32'd0);
        chk("t5_frame_after_rst", frame_no, 32'd0);
        chk("t5_drop_after_rst",  {16'b0, drop_cnt}, 32'd0);
        #1;
        pkt_ready = 1'b1;
        idle(20);
        chk("t5_quiet", {31'b0, pkt_valid}, 32'd0);

`ifdef SPK_REFRACTORY_EN
        got_q.delete();
        sample(1'b1, 1'b0, 1'b1, 8'd3, 32'h0000_0003, 32'h0000_0031);
        repeat (5) sample(1'b1, 1'b1, 1'b0, 8'd31, 32'h0, 32'h0);
        sample(1'b1, 1'b0, 1'b1, 8'd3, 32'h0000_0003, 32'h0000_0033);
        sample(1'b1, 1'b0, 1'b1, 8'd4, 32'h0000_0004, 32'h0000_0041);
        repeat (5) sample(1'b1, 1'b1, 1'b0, 8'd31, 32'h0, 32'h0);
        sample(1'b1, 1'b0, 1'b1, 8'd3, 32'h0000_0003, 32'h0000_0035);
        drain(200);
        chk("rf_words", got_q.size(), 32'd12);
        chk("rf_p0_ch", got_q[0] & 32'hFF, 32'd3);
        chk("rf_p0_fr", got_q[1], 32'd0);
        chk("rf_p1_ch", got_q[4] & 32'hFF, 32'd4);
        chk("rf_p1_fr", got_q[5], 32'd5);
        chk("rf_p2_ch", got_q[8] & 32'hFF, 32'd3);
        chk("rf_p2_fr", got_q[9], 32'd10);
        chk("rf_drop", {16'b0, drop_cnt}, 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit          v, eof, pk;
            logic [31:0] ug, val;
            v         = ($urandom % 4) != 0;
            eof       = v && ($urandom % 10 == 0);
            pk        = v && ($urandom % 12 == 0);
            ug        = $urandom;
            val       = $urandom;
            pkt_ready = ($urandom % 4) != 0;
            sample(v, eof, pk, 8'($urandom % NUM_CH), ug, val);
        end
        pkt_ready = 1'b1;
        drain(600);
        chk("rand_drop", {16'b0, drop_cnt}, drop_m);
        chk("rand_frame_no", frame_no, frame_m);
        chk("rand_idle", {31'b0, pkt_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
